img_filter_frame_ctrl: RTL
==========================

# img_filter_frame_ctrl

Frame-synchronous controller for a chain of 3x3 image filter cores (Gaussian and similar) in the KV260 optical-flow pipeline. It holds CPU-written shadow enables for each filter stage and commits them only at a frame boundary, when no frame is in flight through the chain. It also counts frames, detects missing frames with a timeout, and raises an interrupt. It watches the mat stream at the chain input and output, and drives the per-stage `enable` inputs.

## Interface
Parameters:
- `STAGES`, 4, number of filter stages (one enable bit each)
- `TIMER_BITS`, 24, width of the timeout counter and timeout register
- `FRAME_BITS`, 32, width of the frame counter
- `ADR_BITS`, 3, register address width (word address)
- `DAT_BITS`, 32, register data width (must be ≥ `STAGES`, `TIMER_BITS`, `FRAME_BITS`)

Ports:
- `reset` in 1: asynchronous, active-low reset
- `clk` in 1: single clock for stream and register bus
- `cke` in 1: stream clock enable; qualifies all stream-side logic
- `s_row_first`, `s_col_first`, `s_valid` in 1 each: chain-input stream monitor
- `m_row_last`, `m_col_last`, `m_valid` in 1 each: chain-output stream monitor
- `s_wb_adr` in `ADR_BITS`: register address
- `s_wb_dat_w` in `DAT_BITS`: write data
- `s_wb_sel` in `DAT_BITS/8`: byte enables
- `s_wb_we` in 1: write strobe qualifier
- `s_wb_stb` in 1: bus request
- `s_wb_dat_r` out `DAT_BITS`: read data
- `s_wb_ack` out 1: bus acknowledge
- `enable` out `STAGES`: per-stage filter enable
- `busy` out 1: state ≠ IDLE
- `irq` out 1: interrupt, level

## Operation
Stream events:
- Frame start (FS) = `cke & s_valid & s_row_first & s_col_first`.
- Frame end (FE) = `cke & m_valid & m_row_last & m_col_last`.

In-flight counter, 2 bits:
- FS alone: +1. FE alone: −1. FS and FE in the same cycle: unchanged.
- Saturates at 3 and at 0.
- An FE arriving at count 0 is ignored and sets STATUS.err.

Registers (address: name, access):
- 0: CTL, RW. bit0 `start`, bit1 `oneshot`. Write `start`=1 arms the controller. Write `start`=0 requests stop. `oneshot` auto-clears `start` after one commit.
- 1: STATUS, RO. bit0 busy, bit1 pending, bit2 err (W1C via CTL bit2 written 1), [5:4] in-flight count.
- 2: ENABLE_SHADOW, RW, `STAGES` bits.
- 3: ENABLE_CURRENT, RO.
- 4: TIMEOUT, RW. 0 disables the timeout.
- 5: FRAME_COUNT, RO. Wraps to 0 after all-ones.
- 6: IRQ_STATUS, W1C. bit0 commit, bit1 frame_end, bit2 timeout.
- 7: IRQ_ENABLE, RW.
- Writes to RO addresses are ignored.
- `irq` = |(IRQ_STATUS & IRQ_ENABLE).

FSM:
- IDLE: on CTL.start=1 → ARMED; pending is set.
- ARMED:
  - On FS with in-flight = 0 (value before this cycle's update): `enable` ← shadow, pending ← 0, IRQ_STATUS.commit ← 1, timeout counter cleared → RUN.
  - On FS with in-flight ≠ 0: no commit, stay in ARMED.
  - Timeout counter increments on each `cke` cycle. When it equals TIMEOUT (≠ 0), IRQ_STATUS.timeout ← 1 and the counter holds; stay in ARMED.
- RUN:
  - On FE: FRAME_COUNT+1, IRQ_STATUS.frame_end ← 1.
  - If in-flight becomes 0: go to ARMED if `start`=1, else IDLE.
  - If `oneshot`: `start` was cleared at commit, so the block goes to IDLE.
- Stop request: takes effect at the next return from RUN, or immediately from ARMED. `enable` keeps its last committed value.
- Shadow writes while ARMED or RUN are committed at the next commit. Pending is set on every shadow write.

## Timing
- Reset: `enable`=0, `irq`=0, `busy`=0, `s_wb_ack`=0, `s_wb_dat_r`=0. All registers, counters and the FSM are cleared; FSM = IDLE.
- Register bus:
  - `s_wb_ack` = `s_wb_stb` registered. Single-cycle ack, no wait states; `stb` must drop after `ack`.
  - Read data is valid with `ack`.
  - A write takes effect on the ack cycle. The bus is not gated by `cke`.
- Commit latency: `enable` changes on the clock edge following the FS cycle, i.e. one cycle later. This is within filter line-buffer latency, so the first pixel of the frame sees the new enable.
- A W1C write and a hardware set of the same IRQ bit in the same cycle: the set wins.
- A CTL write and a commit in the same cycle: the write wins for `start`.
- Reset asserted mid-frame: immediate return to the reset state. The in-flight count restarts at 0; the next FE before an FS sets err.

## Structure
- Package `img_filter_frame_ctrl_pkg` holds:
  - register address localparams (ADR_CTL … ADR_IRQ_EN);
  - the state enum `state_t` {IDLE, ARMED, RUN};
  - IRQ bit index constants.
- One sub-module, `img_filter_frame_ctrl_regs`, implements the Wishbone register file: W1C, `sel`, and read mux. The FSM and counters stay in the top module.

## Test plan
- Shadow=4'b0101, `start`=1, FS with in-flight 0 → `enable`=4'b0101 one cycle later; IRQ_STATUS=1; `irq` rises if IRQ_ENABLE[0]=1.
- FS arriving while in-flight=1 (back-to-back frames, short blanking) → no commit, pending=1. Commit happens on the first FS after the FE drains the count to 0.
- TIMEOUT=100, armed, no FS → IRQ_STATUS[2]=1 exactly after 100 `cke` cycles. With `cke` low half the time, the timeout takes 200 clocks.
- `oneshot`=1, `start`=1 → one commit. After that frame's FE, FSM = IDLE, `busy`=0, FRAME_COUNT=1.
- W1C write of IRQ_STATUS bit1 in the same cycle as an FE → bit1 remains 1.
- Reset pulsed low mid-RUN → all outputs 0 asynchronously. A subsequent FE without FS → STATUS.err=1 and in-flight stays 0.

Source files
------------

// File: rtl/img_filter_frame_ctrl_pkg.sv
// Shared constants for the frame-synchronous filter-chain controller:
// register map, FSM state type and IRQ bit positions.
package img_filter_frame_ctrl_pkg;

    // Register word addresses
    localparam int ADR_CTL        = 0;
    localparam int ADR_STATUS     = 1;
    localparam int ADR_EN_SHADOW  = 2;
    localparam int ADR_EN_CURRENT = 3;
    localparam int ADR_TIMEOUT    = 4;
    localparam int ADR_FRAME_CNT  = 5;
    localparam int ADR_IRQ_STAT   = 6;
    localparam int ADR_IRQ_EN     = 7;

    // CTL bits
    localparam int CTL_START   = 0;
    localparam int CTL_ONESHOT = 1;
    localparam int CTL_ERR_CLR = 2;

    // STATUS bits
    localparam int STAT_BUSY     = 0;
    localparam int STAT_PENDING  = 1;
    localparam int STAT_ERR      = 2;
    localparam int STAT_INFL_LSB = 4;

    // IRQ_STATUS / IRQ_ENABLE bits
    localparam int IRQ_COMMIT    = 0;
    localparam int IRQ_FRAME_END = 1;
    localparam int IRQ_TIMEOUT   = 2;
    localparam int IRQ_BITS      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/img_filter_frame_ctrl_if.sv
// Register bus (single-cycle Wishbone-style) between the CPU side and the
// frame controller.
interface img_filter_frame_ctrl_if #(
    parameter int ADR_BITS = 3,
    parameter int DAT_BITS = 32
) ();
    logic [ADR_BITS-1:0]   s_wb_adr;
    logic [DAT_BITS-1:0]   s_wb_dat_w;
    logic [DAT_BITS/8-1:0] s_wb_sel;
    logic                  s_wb_we;
    logic                  s_wb_stb;
    logic [DAT_BITS-1:0]   s_wb_dat_r;
    logic                  s_wb_ack;

    modport master (
        output s_wb_adr, s_wb_dat_w, s_wb_sel, s_wb_we, s_wb_stb,
        input  s_wb_dat_r, s_wb_ack
    );

    modport slave (
        input  s_wb_adr, s_wb_dat_w, s_wb_sel, s_wb_we, s_wb_stb,
        output s_wb_dat_r, s_wb_ack
    );
endinterface

// File: rtl/img_filter_frame_ctrl_regs.sv
// Register file for the frame controller: byte-enabled writes, W1C status
// bits where hardware set beats software clear, and a registered read mux.
module img_filter_frame_ctrl_regs
    import img_filter_frame_ctrl_pkg::*;
#(
    parameter int STAGES     = 4,
    parameter int TIMER_BITS = 24,
    parameter int FRAME_BITS = 32,
    parameter int ADR_BITS   = 3,
    parameter int DAT_BITS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    img_filter_frame_ctrl_if.slave bus,
    input  logic                  commit_evt,
    input  logic                  frame_end_evt,
    input  logic                  timeout_evt,
    input  logic                  err_evt,
    input  logic                  busy,
    input  logic                  pending,
    input  logic [1:0]            inflight,
    input  logic [STAGES-1:0]     enable_cur,
    input  logic [FRAME_BITS-1:0] frame_cnt,
    output logic                  ctl_start,
    output logic [STAGES-1:0]     shadow,
    output logic [TIMER_BITS-1:0] timeout,
    output logic                  shadow_wr,
    output logic                  irq
);

    logic [DAT_BITS-1:0] wmask;
    logic [DAT_BITS-1:0] wbits;
    logic [DAT_BITS-1:0] rdata;
    logic                wr_en;
    logic                wr_ctl;
    logic                wr_timeout;
    logic                wr_irq_stat;
    logic                wr_irq_en;
    logic                ctl_oneshot;
    logic                err;
    logic [IRQ_BITS-1:0] irq_stat;
    logic [IRQ_BITS-1:0] irq_en;
    logic [IRQ_BITS-1:0] irq_set;
    logic [IRQ_BITS-1:0] irq_clr;

    // Expand byte selects into a per-bit write mask
    always_comb begin
        wmask = '0;
        for (int i = 0; i < DAT_BITS; i++) begin
            wmask[i] = bus.s_wb_sel[i/8];
        end
    end

    assign wbits = bus.s_wb_dat_w & wmask;

    // A write lands on the ack cycle, while stb is still held by the master
    assign wr_en       = bus.s_wb_stb & bus.s_wb_we & bus.s_wb_ack;
    assign wr_ctl      = wr_en && (bus.s_wb_adr == ADR_BITS'(ADR_CTL));
    assign shadow_wr   = wr_en && (bus.s_wb_adr == ADR_BITS'(ADR_EN_SHADOW));
    assign wr_timeout  = wr_en && (bus.s_wb_adr == ADR_BITS'(ADR_TIMEOUT));
    assign wr_irq_stat = wr_en && (bus.s_wb_adr == ADR_BITS'(ADR_IRQ_STAT));
    assign wr_irq_en   = wr_en && (bus.s_wb_adr == ADR_BITS'(ADR_IRQ_EN));

    // Hardware events that latch into IRQ_STATUS, and the software W1C mask
    always_comb begin
        irq_set                = '0;
        irq_set[IRQ_COMMIT]    = commit_evt;
        irq_set[IRQ_FRAME_END] = frame_end_evt;
        irq_set[IRQ_TIMEOUT]   = timeout_evt;
        irq_clr                = wr_irq_stat ? wbits[IRQ_BITS-1:0] : '0;
    end

    // CTL: a software write to start takes priority over the oneshot auto-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_start   <= 1'b0;
            ctl_oneshot <= 1'b0;
        end else if (wr_ctl && wmask[CTL_START]) begin
            ctl_start   <= bus.s_wb_dat_w[CTL_START];
            ctl_oneshot <= bus.s_wb_dat_w[CTL_ONESHOT];
        end else if (commit_evt && ctl_oneshot) begin
            ctl_start   <= 1'b0;
        end
    end

    // Plain RW configuration registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow  <= '0;
            timeout <= '0;
            irq_en  <= '0;
        end else begin
            if (shadow_wr)
                shadow <= (shadow & ~wmask[STAGES-1:0]) | wbits[STAGES-1:0];
            if (wr_timeout)
                timeout <= (timeout & ~wmask[TIMER_BITS-1:0]) | wbits[TIMER_BITS-1:0];
            if (wr_irq_en)
                irq_en <= (irq_en & ~wmask[IRQ_BITS-1:0]) | wbits[IRQ_BITS-1:0];
        end
    end

    // Sticky status bits; a same-cycle hardware set survives the clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_stat <= '0;
            err      <= 1'b0;
        end else begin
            irq_stat <= (irq_stat & ~irq_clr) | irq_set;
            if (err_evt)
                err <= 1'b1;
            else if (wr_ctl && wbits[CTL_ERR_CLR])
                err <= 1'b0;
        end
    end

    assign irq = |(irq_stat & irq_en);

    // Read mux, zero-extended to the bus width
    always_comb begin
        rdata = '0;
        case (bus.s_wb_adr)
            ADR_BITS'(ADR_CTL): begin
                rdata[CTL_START]   = ctl_start;
                rdata[CTL_ONESHOT] = ctl_oneshot;
            end
            ADR_BITS'(ADR_STATUS): begin
                rdata[STAT_BUSY]                      = busy;
                rdata[STAT_PENDING]                   = pending;
                rdata[STAT_ERR]                       = err;
                rdata[STAT_INFL_LSB+1:STAT_INFL_LSB]  = inflight;
            end
            ADR_BITS'(ADR_EN_SHADOW):  rdata[STAGES-1:0]     = shadow;
            ADR_BITS'(ADR_EN_CURRENT): rdata[STAGES-1:0]     = enable_cur;
            ADR_BITS'(ADR_TIMEOUT):    rdata[TIMER_BITS-1:0] = timeout;
            ADR_BITS'(ADR_FRAME_CNT):  rdata[FRAME_BITS-1:0] = frame_cnt;
            ADR_BITS'(ADR_IRQ_STAT):   rdata[IRQ_BITS-1:0]   = irq_stat;
            ADR_BITS'(ADR_IRQ_EN):     rdata[IRQ_BITS-1:0]   = irq_en;
            default:                   rdata = '0;
        endcase
    end

    // Single-cycle ack; read data is captured alongside it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.s_wb_ack   <= 1'b0;
            bus.s_wb_dat_r <= '0;
        end else begin
            bus.s_wb_ack <= bus.s_wb_stb & ~bus.s_wb_ack;
            if (bus.s_wb_stb && !bus.s_wb_ack)
                bus.s_wb_dat_r <= rdata;
        end
    end

endmodule

// File: rtl/img_filter_frame_ctrl.sv
// Frame-synchronous enable controller for a chain of 3x3 filter stages.
// Shadow enables are committed only on a frame start while no frame is in
// flight through the chain; also counts frames and flags missing frames.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | stopped; enables hold their last committed value
//   ARMED | waiting for a frame start with an empty chain; timeout runs
//   RUN   | committed; waiting for the chain to drain back to empty
module img_filter_frame_ctrl
    import img_filter_frame_ctrl_pkg::*;
#(
    parameter int STAGES     = 4,
    parameter int TIMER_BITS = 24,
    parameter int FRAME_BITS = 32,
    parameter int ADR_BITS   = 3,
    parameter int DAT_BITS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cke,
    input  logic                  s_row_first,
    input  logic                  s_col_first,
    input  logic                  s_valid,
    input  logic                  m_row_last,
    input  logic                  m_col_last,
    input  logic                  m_valid,
    img_filter_frame_ctrl_if.slave bus,
    output logic [STAGES-1:0]     enable,
    output logic                  busy,
    output logic                  irq
);

    state_t                state;
    logic                  fs;
    logic                  fe;
    logic [1:0]            inflight;
    logic [1:0]            inflight_next;
    logic                  pending;
    logic [TIMER_BITS-1:0] tmo_cnt;
    logic [FRAME_BITS-1:0] frame_cnt;
    logic                  commit_evt;
    logic                  frame_end_evt;
    logic                  timeout_evt;
    logic                  err_evt;
    logic                  ctl_start;
    logic                  shadow_wr;
    logic [STAGES-1:0]     shadow;
    logic [TIMER_BITS-1:0] timeout;

    assign fs = cke & s_valid & s_row_first & s_col_first;
    assign fe = cke & m_valid & m_row_last & m_col_last;

    // Saturating in-flight count; an FE with nothing in flight is an error
    always_comb begin
        inflight_next = inflight;
        err_evt       = 1'b0;
        if (fs && !fe) begin
            if (inflight != 2'd3)
                inflight_next = inflight + 2'd1;
        end else if (fe && !fs) begin
            if (inflight == 2'd0)
                err_evt = 1'b1;
            else
                inflight_next = inflight - 2'd1;
        end
    end

    // Decode FSM events; commit looks at the count before this cycle's update
    always_comb begin
        commit_evt    = (state == ARMED) && ctl_start && fs && (inflight == 2'd0);
        frame_end_evt = (state == RUN) && fe;
        timeout_evt   = (state == ARMED) && ctl_start && !commit_evt && cke
                        && (tmo_cnt == TIMER_BITS'(1));
    end

    // In-flight counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            inflight <= 2'd0;
        else
            inflight <= inflight_next;
    end

    // Frame counter, wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            frame_cnt <= '0;
        else if (frame_end_evt)
            frame_cnt <= frame_cnt + FRAME_BITS'(1);
    end

    // Sequencing FSM; the timeout is a down-counter loaded on entry to ARMED
    // that fires once at terminal count and then holds at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            enable  <= '0;
            pending <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (shadow_wr)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (ctl_start) begin
                        state   <= ARMED;
                        busy    <= 1'b1;
                        pending <= 1'b1;
                        tmo_cnt <= timeout;
                    end
                end
                ARMED: begin
                    if (!ctl_start) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (commit_evt) begin
                        state   <= RUN;
                        enable  <= shadow;
                        tmo_cnt <= '0;
                        // a shadow write landing on the commit edge still needs a commit
                        if (!shadow_wr)
                            pending <= 1'b0;
                    end else if (cke && (tmo_cnt != '0)) begin
                        tmo_cnt <= tmo_cnt - TIMER_BITS'(1);
                    end
                end
                RUN: begin
                    if (inflight_next == 2'd0) begin
                        if (ctl_start) begin
                            state   <= ARMED;
                            tmo_cnt <= timeout;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    img_filter_frame_ctrl_regs #(
        .STAGES     (STAGES),
        .TIMER_BITS (TIMER_BITS),
        .FRAME_BITS (FRAME_BITS),
        .ADR_BITS   (ADR_BITS),
        .DAT_BITS   (DAT_BITS)
    ) u_regs (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .commit_evt    (commit_evt),
        .frame_end_evt (frame_end_evt),
        .timeout_evt   (timeout_evt),
        .err_evt       (err_evt),
        .busy          (busy),
        .pending       (pending),
        .inflight      (inflight),
        .enable_cur    (enable),
        .frame_cnt     (frame_cnt),
        .ctl_start     (ctl_start),
        .shadow        (shadow),
        .timeout       (timeout),
        .shadow_wr     (shadow_wr),
        .irq           (irq)
    );

endmodule
